// File: rtl/load_store_unit_if.sv
// Bundle for the load/store unit. It groups the pipeline request/response
// signals and the single-port memory data bus.
// The slave modport is the unit itself.
// The master modport is the pipeline plus the memory that surround it.
interface load_store_unit_if;
    logic        req;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        done;
    logic        busy;
    logic        misaligned;
    logic [1:0]  memOp;
    logic [31:0] addrB;
    logic [31:0] dinB;
    logic [31:0] doutB;
    logic        bValid;

    modport slave (
        input  req, isStore, funct3, addr, storeData, doutB, bValid,
        output loadData, done, busy, misaligned, memOp, addrB, dinB
    );

    modport master (
        output req, isStore, funct3, addr, storeData, doutB, bValid,
        input  loadData, done, busy, misaligned, memOp, addrB, dinB
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide single-port memory.
// Loads read one word and extract the byte or half lane, with sign or zero extension.
// Word stores write the word directly.
// Byte and half stores do a read-modify-write sequence.
// A misaligned or illegal request completes at once with misaligned=1.
// In that case it never touches memory.
module load_store_unit #(
    parameter logic [1:0] MEM_DISABLE   = 2'b00,
    parameter logic [1:0] MEM_READ_SEXT = 2'b01,
    parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
    parameter logic [1:0] MEM_WRITE     = 2'b11
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_REQ   = 3'd1,
        LD_WAIT  = 3'd2,
        ST_WR    = 3'd3,
        RMW_RD   = 3'd4,
        RMW_WAIT = 3'd5,
        RMW_WR   = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] store_data_q;
    logic        mis_q;
    logic [31:0] load_data_q;
    logic [31:0] merge_q;
    logic        mis_s;
    logic [1:0]  mem_op_s;
    logic [31:0] din_s;

    // Pick the addressed byte/half lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_lane(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'h000000, b};
            3'd5:    r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the targeted byte/half lane of a memory word with store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] w,
                                               input logic [31:0] sd,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  a);
        logic [31:0] r;
        r = w;
        case (f3)
            3'd0:    r[{a, 3'b000} +: 8]        = sd[7:0];
            3'd1:    r[{a[1], 4'b0000} +: 16]   = sd[15:0];
            default: r = w;
        endcase
        return r;
    endfunction

    // Classify the incoming request as misaligned/illegal using the live request fields.
    always_comb begin
        mis_s = 1'b0;
        case (bus.funct3)
            3'd0:    mis_s = 1'b0;
            3'd1:    mis_s = bus.addr[0];
            3'd2:    mis_s = (bus.addr[1:0] != 2'b00);
            3'd4:    mis_s = bus.isStore;
            3'd5:    mis_s = bus.isStore | bus.addr[0];
            default: mis_s = 1'b1;
        endcase
    end

    // Next-state selection; the access type is decided on the acceptance edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!bus.req) begin
                    state_d = IDLE;
                end else if (mis_s) begin
                    state_d = DONE;
                end else if (!bus.isStore) begin
                    state_d = LD_REQ;
                end else if (bus.funct3 == 3'd2) begin
                    state_d = ST_WR;
                end else begin
                    state_d = RMW_RD;
                end
            end
            LD_REQ:   state_d = LD_WAIT;
            LD_WAIT:  state_d = bus.bValid ? DONE : LD_WAIT;
            ST_WR:    state_d = DONE;
            RMW_RD:   state_d = RMW_WAIT;
            RMW_WAIT: state_d = bus.bValid ? RMW_WR : RMW_WAIT;
            RMW_WR:   state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request at acceptance and capture load results and RMW merge words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q     <= 3'd0;
            addr_q       <= 32'h0000_0000;
            store_data_q <= 32'h0000_0000;
            mis_q        <= 1'b0;
            load_data_q  <= 32'h0000_0000;
            merge_q      <= 32'h0000_0000;
        end else begin
            if (state_q == IDLE && bus.req) begin
                funct3_q     <= bus.funct3;
                addr_q       <= bus.addr;
                store_data_q <= bus.storeData;
                mis_q        <= mis_s;
            end
            if (state_q == LD_WAIT && bus.bValid) begin
                load_data_q <= extract_lane(bus.doutB, funct3_q, addr_q[1:0]);
            end
            if (state_q == RMW_WAIT && bus.bValid) begin
                merge_q <= merge_lane(bus.doutB, store_data_q, funct3_q, addr_q[1:0]);
            end
        end
    end

    // Memory port decode from registered state only; dinB is zero unless writing.
    always_comb begin
        mem_op_s = MEM_DISABLE;
        din_s    = 32'h0000_0000;
        case (state_q)
            LD_REQ: begin
                if (funct3_q == 3'd4 || funct3_q == 3'd5) begin
                    mem_op_s = MEM_READ_ZEXT;
                end else begin
                    mem_op_s = MEM_READ_SEXT;
                end
            end
            ST_WR: begin
                mem_op_s = MEM_WRITE;
                din_s    = store_data_q;
            end
            RMW_RD: mem_op_s = MEM_READ_ZEXT;
            RMW_WR: begin
                mem_op_s = MEM_WRITE;
                din_s    = merge_q;
            end
            default: begin
                mem_op_s = MEM_DISABLE;
                din_s    = 32'h0000_0000;
            end
        endcase
    end

    assign bus.memOp      = mem_op_s;
    assign bus.dinB       = din_s;
    assign bus.addrB      = {addr_q[31:2], 2'b00};
    assign bus.loadData   = load_data_q;
    assign bus.done       = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.misaligned = (state_q == DONE) & mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// A behavioural single-port memory with programmable read latency answers the unit.
// Each vector holds a request and its expected outcome.
// The expected record goes into a scoreboard queue when the request is driven.
// It is popped and compared when done rises.
module tb_load_store_unit;

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        int          mem_lat;
        logic [31:0] exp_load;
        logic        exp_mis;
        int          exp_lat;
        logic [1:0]  exp_rd;
        logic        exp_wr;
        logic [31:0] exp_din;
        logic [31:0] exp_mem;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   mem_lat = 1;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rd_data;
    int          rd_cnt;
    vec_t        sb_q[$];
    vec_t        vecs[18];

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural memory: data valid mem_lat cycles after a read op, writes land on the edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[64]    <= 32'h80FF_1234;
            mem[128]   <= 32'h1122_3344;
            bus.bValid <= 1'b0;
            bus.doutB  <= 32'h0;
            rd_cnt     <= 0;
            rd_data    <= 32'h0;
        end else begin
            bus.bValid <= 1'b0;
            if (bus.memOp == 2'b01 || bus.memOp == 2'b10) begin
                if (mem_lat <= 1) begin
                    bus.bValid <= 1'b1;
                    bus.doutB  <= mem[bus.addrB[9:2]];
                end else begin
                    rd_data <= mem[bus.addrB[9:2]];
                    rd_cnt  <= mem_lat - 1;
                end
            end else if (rd_cnt > 1) begin
                rd_cnt <= rd_cnt - 1;
            end else if (rd_cnt == 1) begin
                rd_cnt     <= 0;
                bus.bValid <= 1'b1;
                bus.doutB  <= rd_data;
            end
            if (bus.memOp == 2'b11) mem[bus.addrB[9:2]] <= bus.dinB;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input int lat_m,
                                input logic [31:0] el, input logic em, input int elat,
                                input logic [1:0] erd, input logic ewr,
                                input logic [31:0] edin, input logic [31:0] emem);
        vec_t v;
        v.is_store = st; v.f3 = f3; v.addr = a; v.sd = sd; v.mem_lat = lat_m;
        v.exp_load = el; v.exp_mis = em; v.exp_lat = elat; v.exp_rd = erd;
        v.exp_wr = ewr; v.exp_din = edin; v.exp_mem = emem;
        return v;
    endfunction

    // Drive one request (caller is #1 after a posedge with the unit idle) and check it.
    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        int   cyc, rds, wrs, bad_addr, bad_din, bad_busy, bad_mis;
        logic [1:0]  seen_rd;
        logic [31:0] seen_din;
        logic [31:0] word_addr;
        string       t;
        mem_lat       = v.mem_lat;
        bus.req       = 1'b1;
        bus.isStore   = v.is_store;
        bus.funct3    = v.f3;
        bus.addr      = v.addr;
        bus.storeData = v.sd;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        bus.req       = 1'b0;
        bus.isStore   = ~v.is_store;
        bus.funct3    = 3'($urandom_range(0, 7));
        bus.addr      = $urandom;
        bus.storeData = $urandom;
        word_addr = {v.addr[31:2], 2'b00};
        cyc = 1; rds = 0; wrs = 0; bad_addr = 0; bad_din = 0; bad_busy = 0; bad_mis = 0;
        seen_rd = 2'b00; seen_din = 32'h0;
        while (cyc <= 40) begin
            if (bus.memOp != 2'b00 && bus.addrB !== word_addr) bad_addr++;
            if (bus.memOp != 2'b11 && bus.dinB !== 32'h0) bad_din++;
            if (bus.busy !== 1'b1) bad_busy++;
            if (!bus.done && bus.misaligned !== 1'b0) bad_mis++;
            if (bus.memOp == 2'b01 || bus.memOp == 2'b10) begin rds++; seen_rd = bus.memOp; end
            if (bus.memOp == 2'b11) begin wrs++; seen_din = bus.dinB; end
            if (bus.done === 1'b1) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        t = $sformatf("v%0d", idx);
        if (bus.done !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected done at cycle %0d", t, v.exp_lat);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        chk({t, "_latency"},    32'(cyc),      32'(e.exp_lat));
        chk({t, "_misaligned"}, 32'(bus.misaligned), 32'(e.exp_mis));
        chk({t, "_loadData"},   bus.loadData,  e.exp_load);
        chk({t, "_rd_op"},      32'(seen_rd),  32'(e.exp_rd));
        chk({t, "_rd_cycles"},  32'(rds),      (e.exp_rd != 2'b00) ? 32'd1 : 32'd0);
        chk({t, "_wr_cycles"},  32'(wrs),      32'(e.exp_wr));
        chk({t, "_dinB"},       seen_din,      e.exp_din);
        chk({t, "_bus_rules"},  32'(bad_addr + bad_din + bad_busy + bad_mis), 32'd0);
        // A request raised during DONE must be ignored.
        bus.req = 1'b1; bus.isStore = 1'b1; bus.funct3 = 3'd2;
        bus.addr = 32'h0000_0100; bus.storeData = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk({t, "_idle_after_done"}, {30'h0, bus.busy, bus.done}, 32'd0);
        chk({t, "_mem_word"}, mem[word_addr[9:2]], e.exp_mem);
    endtask

    initial begin
        bus.req = 1'b0; bus.isStore = 1'b0; bus.funct3 = 3'd0;
        bus.addr = 32'h0; bus.storeData = 32'h0;

        //            st    f3    addr          sd            lat loadData      mis lat rd     wr    dinB          mem word after
        vecs[0]  = mk(1'b0, 3'd0, 32'h0000_0103, 32'h0,        1, 32'hFFFF_FF80, 1'b0, 3, 2'b01, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[1]  = mk(1'b0, 3'd5, 32'h0000_0102, 32'h0,        1, 32'h0000_80FF, 1'b0, 3, 2'b10, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[2]  = mk(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 1, 32'h0000_80FF, 1'b0, 4, 2'b10, 1'b1, 32'h1122_AB44, 32'h1122_AB44);
        vecs[3]  = mk(1'b1, 3'd2, 32'h0000_0204, 32'hDEAD_BEEF, 1, 32'h0000_80FF, 1'b0, 2, 2'b00, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        vecs[4]  = mk(1'b0, 3'd2, 32'h0000_0102, 32'h0,        1, 32'h0000_80FF, 1'b1, 1, 2'b00, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[5]  = mk(1'b0, 3'd1, 32'h0000_0100, 32'h0,        1, 32'h0000_1234, 1'b0, 3, 2'b01, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[6]  = mk(1'b0, 3'd1, 32'h0000_0102, 32'h0,        1, 32'hFFFF_80FF, 1'b0, 3, 2'b01, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[7]  = mk(1'b0, 3'd4, 32'h0000_0102, 32'h0,        1, 32'h0000_00FF, 1'b0, 3, 2'b10, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[8]  = mk(1'b0, 3'd2, 32'h0000_0204, 32'h0,        1, 32'hDEAD_BEEF, 1'b0, 3, 2'b01, 1'b0, 32'h0,        32'hDEAD_BEEF);
        vecs[9]  = mk(1'b1, 3'd1, 32'h0000_0202, 32'h1234_5678, 1, 32'hDEAD_BEEF, 1'b0, 4, 2'b10, 1'b1, 32'h5678_AB44, 32'h5678_AB44);
        vecs[10] = mk(1'b1, 3'd1, 32'h0000_0203, 32'h1234_5678, 1, 32'hDEAD_BEEF, 1'b1, 1, 2'b00, 1'b0, 32'h0,        32'h5678_AB44);
        vecs[11] = mk(1'b0, 3'd3, 32'h0000_0100, 32'h0,        1, 32'hDEAD_BEEF, 1'b1, 1, 2'b00, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[12] = mk(1'b1, 3'd4, 32'h0000_0200, 32'h0000_0011, 1, 32'hDEAD_BEEF, 1'b1, 1, 2'b00, 1'b0, 32'h0,        32'h5678_AB44);
        vecs[13] = mk(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00CD, 2, 32'hDEAD_BEEF, 1'b0, 5, 2'b10, 1'b1, 32'hCD78_AB44, 32'hCD78_AB44);
        vecs[14] = mk(1'b0, 3'd0, 32'h0000_0200, 32'h0,        3, 32'h0000_0044, 1'b0, 5, 2'b01, 1'b0, 32'h0,        32'hCD78_AB44);
        vecs[15] = mk(1'b0, 3'd0, 32'h0000_0203, 32'h0,        1, 32'hFFFF_FFCD, 1'b0, 3, 2'b01, 1'b0, 32'h0,        32'hCD78_AB44);
        vecs[16] = mk(1'b0, 3'd5, 32'h0000_0100, 32'h0,        1, 32'h0000_1234, 1'b0, 3, 2'b10, 1'b0, 32'h0,        32'h80FF_1234);
        vecs[17] = mk(1'b0, 3'd6, 32'h0000_0204, 32'h0,        1, 32'h0000_1234, 1'b1, 1, 2'b00, 1'b0, 32'h0,        32'hDEAD_BEEF);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_loadData",   bus.loadData, 32'h0);
        chk("rst_flags",      {29'h0, bus.done, bus.busy, bus.misaligned}, 32'h0);
        chk("rst_memOp",      32'(bus.memOp), 32'h0);
        chk("rst_dinB",       bus.dinB, 32'h0);
        chk("rst_addrB",      bus.addrB, 32'h0);
        mem_init = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors; the first is accepted on the first edge after reset release.
        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // Reset during RMW_WAIT: the pending write must never be issued.
        mem_lat       = 6;
        bus.req       = 1'b1;
        bus.isStore   = 1'b1;
        bus.funct3    = 3'd0;
        bus.addr      = 32'h0000_0205;
        bus.storeData = 32'h0000_0077;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rmw_wait_busy",  32'(bus.busy), 32'd1);
        chk("rmw_wait_memOp", 32'(bus.memOp), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_memOp",    32'(bus.memOp), 32'd0);
        chk("midrst_flags",    {29'h0, bus.done, bus.busy, bus.misaligned}, 32'h0);
        chk("midrst_loadData", bus.loadData, 32'h0);
        chk("midrst_dinB",     bus.dinB, 32'h0);
        chk("midrst_addrB",    bus.addrB, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_mem_word", mem[8'd129], 32'hDEAD_BEEF);
        run_vec(100, mk(1'b0, 3'd2, 32'h0000_0204, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 3,
                        2'b01, 1'b0, 32'h0, 32'hDEAD_BEEF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
